// File: rtl/anim_pkg.sv
// Shared constants and state encoding for the animation frame sequencer.
package anim_pkg;

  localparam logic [8:0] SCREEN_W = 9'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;
  localparam int         COLOUR_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERASE = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    ERASE = S_ERASE,
    LATCH = S_LATCH,
    DRAW  = S_DRAW,
    DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/anim_frame_ctrl_if.sv
// Pixel write port from the frame sequencer to the VGA adapter.
interface anim_frame_ctrl_if
  import anim_pkg::*;
();
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                plot;

  modport master (output vga_x, vga_y, vga_colour, plot);
  modport slave  (input  vga_x, vga_y, vga_colour, plot);
endinterface

// File: rtl/anim_frame_ctrl_box_scan.sv
// Raster scan of a SIZE x SIZE box, dx fastest; wraps to (0,0) after the last pixel.
module box_scan #(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  localparam logic [3:0] LIM = 4'(SIZE - 1);

  assign last = (dx == LIM) && (dy == LIM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= '0;
      dy <= '0;
    end else if (advance) begin
      if (dx == LIM) begin
        dx <= '0;
        dy <= (dy == LIM) ? 4'd0 : dy + 4'd1;
      end else begin
        dx <= dx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/anim_frame_ctrl.sv
// Per-frame erase / latch / draw sequencer feeding the VGA adapter pixel port.
//   state | meaning
//   IDLE  | waiting for a step edge
//   ERASE | repaint previous box in BG_COLOUR (suppressed before first latch)
//   LATCH | capture new position and colour
//   DRAW  | paint box at new position
//   DONE  | frame_done next cycle; chain into a queued frame if any
module anim_frame_ctrl
  import anim_pkg::*;
#(
  parameter int                  SIZE      = 4,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                step_tgl,
  input  logic [7:0]          pos_x,
  input  logic [6:0]          pos_y,
  input  logic [COLOUR_W-1:0] colour,
  anim_frame_ctrl_if.master   vga,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  state_t              state, state_nx;
  logic                step_q, step;
  logic                pending, have_old;
  logic [7:0]          old_x;
  logic [6:0]          old_y;
  logic [COLOUR_W-1:0] draw_col;
  logic [3:0]          dx, dy;
  logic                last;
  logic                scanning;
  logic [8:0]          sum_x;
  logic [7:0]          sum_y;
  logic                in_bounds, pix_plot;
  logic [COLOUR_W-1:0] pix_col;

  assign step     = (step_tgl != step_q) && enable;
  assign scanning = (state == ERASE) || (state == DRAW);

  box_scan #(.SIZE(SIZE)) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (!scanning),
    .advance (scanning),
    .dx      (dx),
    .dy      (dy),
    .last    (last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (step) state_nx = ERASE;
      ERASE:   if (last) state_nx = LATCH;
      LATCH:   state_nx = DRAW;
      DRAW:    if (last) state_nx = DONE;
      DONE:    state_nx = (pending || step) ? ERASE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Widened sums so off-screen pixels are clipped rather than wrapped.
  always_comb begin
    sum_x     = {1'b0, old_x} + {5'b0, dx};
    sum_y     = {1'b0, old_y} + {4'b0, dy};
    in_bounds = (sum_x < SCREEN_W) && (sum_y < SCREEN_H);
    pix_plot  = in_bounds && ((state == DRAW) || ((state == ERASE) && have_old));
    pix_col   = (state == DRAW) ? draw_col : BG_COLOUR;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_q         <= step_tgl;
      state          <= IDLE;
      pending        <= 1'b0;
      overrun        <= 1'b0;
      have_old       <= 1'b0;
      old_x          <= '0;
      old_y          <= '0;
      draw_col       <= '0;
      vga.vga_x      <= '0;
      vga.vga_y      <= '0;
      vga.vga_colour <= '0;
      vga.plot       <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      step_q <= step_tgl;
      state  <= state_nx;

      if (state == LATCH) begin
        old_x    <= pos_x;
        old_y    <= pos_y;
        draw_col <= colour;
        have_old <= 1'b1;
      end

      // A step landing in DONE while one is already queued replaces it.
      if (!enable) begin
        pending <= 1'b0;
      end else if (state == DONE) begin
        pending <= pending && step;
      end else if ((state != IDLE) && step) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      vga.plot <= pix_plot;
      if (pix_plot) begin
        vga.vga_x      <= sum_x[7:0];
        vga.vga_y      <= sum_y[6:0];
        vga.vga_colour <= pix_col;
      end

      busy       <= (state_nx != IDLE) || (state == DONE);
      frame_done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_anim_frame_ctrl.sv
// Directed bench for anim_frame_ctrl: frame vectors plus queuing, enable and reset sequences.
module tb_anim_frame_ctrl;
  import anim_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b1;
  logic       step_tgl = 1'b0;
  logic [7:0] pos_x = '0;
  logic [6:0] pos_y = '0;
  logic [2:0] colour = '0;
  logic       busy, frame_done, overrun;

  anim_frame_ctrl_if vga_if ();

  anim_frame_ctrl #(.SIZE(4), .BG_COLOUR(3'b000)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .step_tgl   (step_tgl),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .colour     (colour),
    .vga        (vga_if.master),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] col;
    int         exp_erase;
    int         exp_draw;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;

  int   m_ox = 0, m_oy = 0;
  bit   m_have = 0;
  int   m_ovr = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int idx);
    vec_t v;
    int ep, dp, p, ex, ey, ec;
    bit eplot;
    int last_x, last_y, last_c;
    v = vecs[idx];
    ep = 0; dp = 0;
    last_x = int'(vga_if.vga_x); last_y = int'(vga_if.vga_y); last_c = int'(vga_if.vga_colour);
    pos_x = v.px; pos_y = v.py; colour = v.col;
    step_tgl = ~step_tgl;
    for (int off = 1; off <= 36; off++) begin
      tick();
      eplot = 0; ex = 0; ey = 0; ec = 0;
      if (off >= 2 && off <= 17) begin
        p = off - 2;
        ex = m_ox + p % 4; ey = m_oy + p / 4; ec = 0;
        eplot = m_have && ex < 160 && ey < 120;
      end else if (off >= 19 && off <= 34) begin
        p = off - 19;
        ex = int'(v.px) + p % 4; ey = int'(v.py) + p / 4; ec = int'(v.col);
        eplot = ex < 160 && ey < 120;
      end
      chk($sformatf("plot[v%0d off%0d]", idx, off), int'(vga_if.plot), int'(eplot));
      if (eplot && vga_if.plot) begin
        chk($sformatf("x[v%0d off%0d]", idx, off), int'(vga_if.vga_x), ex);
        chk($sformatf("y[v%0d off%0d]", idx, off), int'(vga_if.vga_y), ey);
        chk($sformatf("col[v%0d off%0d]", idx, off), int'(vga_if.vga_colour), ec);
        last_x = ex; last_y = ey; last_c = ec;
      end
      if (vga_if.plot) begin
        if (off <= 18) ep++;
        else dp++;
      end
      chk($sformatf("busy[v%0d off%0d]", idx, off), int'(busy), int'(off <= 35));
      chk($sformatf("frame_done[v%0d off%0d]", idx, off), int'(frame_done), int'(off == 35));
    end
    chk($sformatf("hold_x[v%0d]", idx), int'(vga_if.vga_x), last_x);
    chk($sformatf("hold_y[v%0d]", idx), int'(vga_if.vga_y), last_y);
    chk($sformatf("hold_col[v%0d]", idx), int'(vga_if.vga_colour), last_c);
    chk($sformatf("erase_plots[v%0d]", idx), ep, v.exp_erase);
    chk($sformatf("draw_plots[v%0d]", idx), dp, v.exp_draw);
    chk($sformatf("overrun[v%0d]", idx), int'(overrun), m_ovr);
    m_ox = int'(v.px); m_oy = int'(v.py); m_have = 1;
  endtask

  // Runs a window of n cycles after a step, optionally toggling again at t1/t2.
  task automatic run_window(input int n, input int t1, input int t2,
                            output int fd_cnt, output int fd_first, output int fd_second,
                            output int busy_low_at);
    fd_cnt = 0; fd_first = -1; fd_second = -1; busy_low_at = -1;
    step_tgl = ~step_tgl;
    for (int off = 1; off <= n; off++) begin
      tick();
      if (frame_done) begin
        fd_cnt++;
        if (fd_cnt == 1) fd_first = off;
        if (fd_cnt == 2) fd_second = off;
      end
      if (!busy && busy_low_at < 0) busy_low_at = off;
      if (off == t1 || off == t2) step_tgl = ~step_tgl;
    end
  endtask

  initial begin
    int fd_cnt, fd1, fd2, bl;

    vecs[0] = '{8'd10,  7'd20,  3'd4, 0,  16};
    vecs[1] = '{8'd30,  7'd20,  3'd4, 16, 16};
    vecs[2] = '{8'd158, 7'd118, 3'd5, 16, 4};
    vecs[3] = '{8'd0,   7'd0,   3'd2, 4,  16};
    vecs[4] = '{8'd157, 7'd0,   3'd7, 16, 12};
    vecs[5] = '{8'd20,  7'd30,  3'd1, 12, 16};
    vecs[6] = '{8'd5,   7'd5,   3'd6, 0,  16};

    repeat (3) tick();
    chk("rst_plot", int'(vga_if.plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_x", int'(vga_if.vga_x), 0);
    resetn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) begin
      run_frame(i);
      repeat (2) tick();
    end

    // Single step mid-DRAW chains a second frame straight out of DONE.
    run_window(75, 20, -1, fd_cnt, fd1, fd2, bl);
    chk("queued_fd_cnt", fd_cnt, 2);
    chk("queued_fd_first", fd1, 35);
    chk("queued_fd_second", fd2, 69);
    chk("queued_busy_low", bl, 70);
    chk("queued_overrun", int'(overrun), 0);

    // Two steps mid-frame: one extra frame only, overrun latched.
    run_window(110, 10, 12, fd_cnt, fd1, fd2, bl);
    chk("ovr_fd_cnt", fd_cnt, 2);
    chk("ovr_fd_second", fd2, 69);
    chk("ovr_busy_low", bl, 70);
    chk("ovr_set", int'(overrun), 1);
    m_ovr = 1;
    repeat (5) tick();
    chk("ovr_held", int'(overrun), 1);

    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_tgl = ~step_tgl;
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("en0_plot[%0d.%0d]", k, c), int'(vga_if.plot), 0);
        chk($sformatf("en0_busy[%0d.%0d]", k, c), int'(busy), 0);
        chk($sformatf("en0_done[%0d.%0d]", k, c), int'(frame_done), 0);
      end
    end
    enable = 1'b1;
    tick();
    run_frame(5);
    repeat (2) tick();

    step_tgl = ~step_tgl;
    repeat (25) tick();
    chk("pre_rst_plot", int'(vga_if.plot), 1);
    chk("pre_rst_busy", int'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_plot", int'(vga_if.plot), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_overrun", int'(overrun), 0);
    m_have = 0; m_ovr = 0;
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    run_frame(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/anim_frame_ctrl.md
Name: anim_frame_ctrl

Overview:
- Per-frame sequencer between the animation tick/position logic and the VGA adapter pixel port.
- On each step of the toggling tick it does three things in order:
  - erases the shape's previous box in the background colour;
  - latches the new top-left position and colour;
  - draws the new box, one pixel per clock.
- Frame timing is fixed, independent of clipping, so upstream tick periods can be budgeted exactly.

Parameters:
- SIZE, 4, box width and height in pixels (1..15).
- BG_COLOUR, 3'b000, colour used for the erase pass.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  when high, step edges are accepted.
- step_tgl  in  1  tick from the tick generator; every change of level is one step. Synchronous to clk.
- pos_x  in  8  new top-left x (0..159 valid).
- pos_y  in  7  new top-left y (0..119 valid).
- colour  in  3  draw colour.
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- vga_colour  out  3  pixel colour.
- plot  out  1  write strobe for the adapter, one pixel per high cycle.
- busy  out  1  high from the cycle a frame starts to the cycle frame_done is high, inclusive.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- overrun  out  1  sticky; set when a step is lost.

Behaviour:
- Reset (asynchronous, resetn=0):
  - All outputs go to 0.
  - FSM goes to IDLE; pending, overrun and have_old are cleared.
  - step_q is loaded with step_tgl.
- Step detect:
  - step_q <= step_tgl every cycle.
  - A step is present in cycle T when step_tgl != step_q and enable=1. With enable=0, steps are dropped and not queued.
- FSM states: IDLE, ERASE, LATCH, DRAW, DONE.
  - IDLE: a step in cycle T moves to ERASE in T+1.
  - ERASE: exactly SIZE*SIZE cycles. Scan counters dx, dy run 0..SIZE-1 in raster order, dx fastest. Base is (old_x, old_y), colour is BG_COLOUR. Then go to LATCH.
  - LATCH: one cycle.
    - old_x <= pos_x, old_y <= pos_y, draw_col <= colour.
    - have_old <= 1.
    - Scan counters clear.
  - DRAW: exactly SIZE*SIZE cycles, base (old_x, old_y), colour draw_col. Then go to DONE.
  - DONE: one cycle. If pending=1, clear pending and go to ERASE; otherwise go to IDLE.
- Pixel gating:
  - plot=1 only in ERASE or DRAW, and only when the pixel is in bounds.
  - In bounds means base_x+dx < 160 and base_y+dy < 120. Sums use 9-bit (x) and 8-bit (y) arithmetic; no wrap.
  - In ERASE, plot is also forced to 0 while have_old=0 (first frame after reset).
  - Clipped and suppressed pixels still consume their cycle.
- Output timing:
  - All outputs are registered and reflect the previous cycle's state and counters.
  - A step detected in cycle T gives the first ERASE pixel at T+2 and the first DRAW pixel at T+SIZE*SIZE+3.
  - frame_done is high at T+2*SIZE*SIZE+3; with SIZE=4 that is T+35.
  - vga_x, vga_y and vga_colour hold their last value when plot=0.
- Queuing while busy (FSM not in IDLE):
  - First step: pending <= 1.
  - Further step while pending=1: overrun <= 1 (sticky until reset).
  - A step in the DONE cycle counts as pending.
  - Any step while FSM is in IDLE starts a frame as normal, including a step in the same cycle frame_done is high.
- enable falling mid-frame: the current frame completes; pending is cleared.
- Inputs pos_x, pos_y and colour are sampled only in LATCH.

Decomposition:
- anim_pkg (shared package) holds:
  - SCREEN_W=160 and SCREEN_H=120;
  - COLOUR_W=3;
  - the FSM state encoding localparams (IDLE=0, ERASE=1, LATCH=2, DRAW=3, DONE=4).
- One sub-module, box_scan:
  - inputs: clear and advance;
  - outputs: dx, dy and last;
  - parameter SIZE.
  - It is instantiated once and shared by the ERASE and DRAW passes.

Test Plan:
1. First frame:
   - Stimulus: reset, enable=1, pos=(10,20), colour=3'b100, toggle step_tgl at T.
   - Required: no plot during T+2..T+17; then 16 plots covering x 10..13, y 20..23 in raster order, colour 4; frame_done at T+35; busy high T+1..T+35.
2. Second frame:
   - Stimulus: pos=(30,20), toggle step_tgl.
   - Required: 16 plots at (10..13, 20..23) colour 0, then 16 plots at (30..33, 20..23) colour 4.
3. Clipping:
   - Stimulus: pos=(158,118), SIZE=4.
   - Required: DRAW plots only (158,118), (159,118), (158,119), (159,119); frame_done still at T+35; no wrapped coordinates.
4. Queued step and overrun:
   - Stimulus: toggle step_tgl once mid-DRAW.
   - Required: DONE is followed directly by ERASE; overrun=0.
   - Stimulus: toggle step_tgl twice mid-frame.
   - Required: overrun=1 and held; only one extra frame is run.
5. Enable low:
   - Stimulus: enable=0, toggle step_tgl 3 times.
   - Required: plot, busy and frame_done stay 0; the next toggle with enable=1 starts normally.
6. Reset mid-operation:
   - Stimulus: assert resetn=0 mid-DRAW.
   - Required: plot and busy drop to 0 immediately, without waiting for a clock edge; the next step behaves as a first frame (ERASE suppressed).
